rx_lane_sync_ctrl: RTL

RX_LANE_SYNC_CTRL -- requirements
Module: rx_lane_sync_ctrl

---
 rtl/rx_lane_sync_ctrl_pkg.sv | 21 ++
 rtl/rx_err_leaky_cnt.sv | 65 ++++++
 rtl/rx_lane_sync_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rx_lane_sync_ctrl_pkg.sv
// Shared constants for the RX lane synchroniser: FSM encodings, default
// parameter values and the 8b/10b ordered-set symbol codes.
package rx_lane_sync_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_LOST    = 2'd3;

    localparam int LOCK_CNT_DEF = 4;
    localparam int ERR_MAX_DEF  = 4;
    localparam int GOOD_RUN_DEF = 16;
    localparam int TIMEOUT_DEF  = 1024;

    localparam logic [7:0] SYM_COM = 8'hBC;   // K28.5
    localparam logic [7:0] SYM_SKP = 8'h1C;   // K28.0
    localparam logic [7:0] SYM_FTS = 8'h3C;   // K28.1
    localparam logic [7:0] SYM_IDL = 8'h7C;   // K28.3
    localparam logic [7:0] SYM_EIE = 8'hFC;   // K28.7

endpackage

// File: rtl/rx_err_leaky_cnt.sv
// Leaky-bucket error counter: errors add one (saturating), every GOOD_RUN
// consecutive clean valid symbols remove one (floor zero). Held at zero
// whenever run is low.
module rx_err_leaky_cnt
    import rx_lane_sync_ctrl_pkg::*;
#(
    parameter int ERR_MAX  = ERR_MAX_DEF,
    parameter int GOOD_RUN = GOOD_RUN_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic                         rx_valid,
    input  logic                         rx_err,
    output logic [$clog2(ERR_MAX+1)-1:0] err_cnt,
    output logic                         err_max_hit
);

    localparam int EW = $clog2(ERR_MAX + 1);
    localparam int GW = $clog2(GOOD_RUN + 1);
    localparam logic [EW-1:0] ERR_MAX_C   = EW'(ERR_MAX);
    localparam logic [GW-1:0] GOOD_LAST_C = GW'(GOOD_RUN - 1);

    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic [GW-1:0] good_q, good_d;

    // Next-count logic; an error in the same cycle as a valid symbol counts as an error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        good_d    = good_q;
        if (!run) begin
            err_cnt_d = '0;
            good_d    = '0;
        end else if (rx_err) begin
            good_d = '0;
            if (err_cnt_q != ERR_MAX_C) begin
                err_cnt_d = err_cnt_q + EW'(1);
            end
        end else if (rx_valid) begin
            if (good_q == GOOD_LAST_C) begin
                good_d = '0;
                if (err_cnt_q != '0) begin
                    err_cnt_d = err_cnt_q - EW'(1);
                end
            end else begin
                good_d = good_q + GW'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            good_q    <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            good_q    <= good_d;
        end
    end

    assign err_cnt     = err_cnt_q;
    assign err_max_hit = (err_cnt_d == ERR_MAX_C);

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// RX lane synchronisation controller: acquires lock on consecutive clean
// COM symbols, drops lock on accumulated errors or a COM timeout.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | disabled, detector off, all counters clear
//   ACQUIRE | counting consecutive error-free COM detections
//   LOCKED  | lane locked; leaky error count and COM timeout running
//   LOST    | one-cycle loss-of-lock pulse, then back to ACQUIRE
module rx_lane_sync_ctrl
    import rx_lane_sync_ctrl_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_MAX  = ERR_MAX_DEF,
    parameter int GOOD_RUN = GOOD_RUN_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic                         k285,
    input  logic                         rx_Valid,
    input  logic                         rx_err,
    output logic                         det_enb,
    output logic                         lane_lock,
    output logic [1:0]                   lock_state,
    output logic [$clog2(ERR_MAX+1)-1:0] err_cnt,
    output logic                         lock_lost
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOCK_LAST_C = CW'(LOCK_CNT - 1);
    localparam logic [TW-1:0] TIMEOUT_C   = TW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] com_q, com_d;
    logic [TW-1:0] tmo_q, tmo_d;     // cycles remaining before COM timeout
    logic          det_enb_q, det_enb_d;
    logic          lane_lock_q, lane_lock_d;
    logic          lock_lost_q, lock_lost_d;
    logic          err_run;
    logic          err_max_hit;

    assign err_run = enb && (state_q == ST_LOCKED);

    rx_err_leaky_cnt #(
        .ERR_MAX  (ERR_MAX),
        .GOOD_RUN (GOOD_RUN)
    ) u_err_cnt (
        .clk         (clk),
        .rst_n       (rst),
        .run         (err_run),
        .rx_valid    (rx_Valid),
        .rx_err      (rx_err),
        .err_cnt     (err_cnt),
        .err_max_hit (err_max_hit)
    );

    // FSM, COM counter and timeout down-counter; outputs decoded from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        com_d   = com_q;
        tmo_d   = tmo_q;
        if (!enb) begin
            state_d = ST_IDLE;
            com_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (rx_err) begin
                        com_d = '0;
                    end else if (k285) begin
                        if (com_q == LOCK_LAST_C) begin
                            state_d = ST_LOCKED;
                            com_d   = '0;
                            tmo_d   = TIMEOUT_C;
                        end else begin
                            com_d = com_q + CW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    tmo_d = k285 ? TIMEOUT_C : tmo_q - TW'(1);
                    if (err_max_hit || (!k285 && tmo_q == TW'(1))) begin
                        state_d = ST_LOST;
                        tmo_d   = '0;
                    end
                end
                ST_LOST: begin
                    state_d = ST_ACQUIRE;
                    com_d   = '0;
                    tmo_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    com_d   = '0;
                    tmo_d   = '0;
                end
            endcase
        end
        det_enb_d   = (state_d != ST_IDLE);
        lane_lock_d = (state_d == ST_LOCKED);
        lock_lost_d = (state_d == ST_LOST);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            com_q       <= '0;
            tmo_q       <= '0;
            det_enb_q   <= 1'b0;
            lane_lock_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            com_q       <= com_d;
            tmo_q       <= tmo_d;
            det_enb_q   <= det_enb_d;
            lane_lock_q <= lane_lock_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign lock_state = state_q;
    assign det_enb    = det_enb_q;
    assign lane_lock  = lane_lock_q;
    assign lock_lost  = lock_lost_q;

endmodule
